// File: rtl/afifo_pkt_writer_if.sv
// Packet-writer port bundle: request, payload stream, FIFO write side and status.
// Stream rule: a payload word moves on a wclk edge exactly when src_valid && src_ready.
interface afifo_pkt_writer_if #(
    parameter int DW = 4,
    parameter int LW = 4
);
    logic          start;
    logic [LW-1:0] len;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          fifo_full;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wdata;
    logic          busy;
    logic          done;

    modport master (
        output start, len, src_valid, src_data, fifo_full,
        input  src_ready, fifo_wr_en, fifo_wdata, busy, done
    );

    modport slave (
        input  start, len, src_valid, src_data, fifo_full,
        output src_ready, fifo_wr_en, fifo_wdata, busy, done
    );
endinterface

// File: rtl/afifo_pkt_writer.sv
// Frames a payload stream into the async FIFO as header(len), payload words, XOR checksum.
// Every FIFO write is gated in the same cycle by the registered full flag.
module afifo_pkt_writer #(
    parameter int DW = 4,
    parameter int LW = 4
) (
    input  logic                wclk,
    input  logic                wrstn,
    afifo_pkt_writer_if.slave   bus,
    output logic [2:0]          dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        PAY  = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] csum_q, csum_d;
    logic [DW-1:0] hdr;
    logic [LW:0]   cnt_inc;

    always_ff @(posedge wclk or negedge wrstn) begin
        if (!wrstn) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        cnt_d          = cnt_q;
        csum_d         = csum_q;
        bus.fifo_wr_en = 1'b0;
        bus.fifo_wdata = '0;
        bus.src_ready  = 1'b0;
        hdr            = '0;
        hdr[LW-1:0]    = len_q;
        // One bit wider so len = 2^LW-1 is reached without wrapping.
        cnt_inc        = {1'b0, cnt_q} + (LW+1)'(1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    cnt_d   = '0;
                    csum_d  = '0;
                    state_d = HDR;
                end
            end
            HDR: begin
                bus.fifo_wr_en = ~bus.fifo_full;
                if (!bus.fifo_full) begin
                    bus.fifo_wdata = hdr;
                    csum_d         = csum_q ^ hdr;
                    state_d        = (len_q != '0) ? PAY : CSUM;
                end
            end
            PAY: begin
                bus.src_ready  = ~bus.fifo_full;
                bus.fifo_wr_en = bus.src_valid & ~bus.fifo_full;
                if (bus.src_valid && !bus.fifo_full) begin
                    bus.fifo_wdata = bus.src_data;
                    csum_d         = csum_q ^ bus.src_data;
                    cnt_d          = cnt_inc[LW-1:0];
                    if (cnt_inc == {1'b0, len_q}) state_d = CSUM;
                end
            end
            CSUM: begin
                bus.fifo_wr_en = ~bus.fifo_full;
                if (!bus.fifo_full) begin
                    bus.fifo_wdata = csum_q;
                    state_d        = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_afifo_pkt_writer.sv
// Randomized bench for afifo_pkt_writer: a frame-level model (expected word queue plus
// word kinds) is checked against the DUT outputs on every falling edge.
module tb_afifo_pkt_writer;
    localparam int DW = 4;
    localparam int LW = 4;

    // ---------------- clock / reset ----------------
    logic       wclk  = 1'b0;
    logic       wrstn = 1'b0;
    logic [2:0] dbg_state;

    always #5 wclk = ~wclk;

    afifo_pkt_writer_if #(.DW(DW), .LW(LW)) bus();

    afifo_pkt_writer #(.DW(DW), .LW(LW)) dut (
        .wclk      (wclk),
        .wrstn     (wrstn),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- model / scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];      // words the FIFO must receive, in order
    int            kind_q[$];     // 0 header, 1 payload, 2 checksum
    bit            m_done_pend;
    logic [DW-1:0] src_q[$];      // payload words still to be offered
    logic [DW-1:0] pay_q[$];      // payload of the next packet to start
    logic [DW-1:0] wr_log[$];     // every word the DUT actually wrote
    int            busy_cycles;
    int            valid_pct = 100;
    int            valid_mode = 0;
    int            full_pct = 0;
    int            full_hold = 0;
    int            ign_start_pct = 0;
    int            cyc = 0;

    bit exp_ready, exp_wr, exp_busy, exp_done, have;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit model_busy();
        return (kind_q.size() != 0) || m_done_pend;
    endfunction

    function automatic logic [DW-1:0] pkt_csum(input logic [LW-1:0] n);
        logic [DW-1:0] c;
        c = '0;
        c[LW-1:0] = n;
        foreach (pay_q[i]) c ^= pay_q[i];
        return c;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge wclk) begin
        if (!wrstn) begin
            check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
            check("rst_src_ready", 32'(bus.src_ready), 32'd0);
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            exp_q.delete();
            kind_q.delete();
            m_done_pend = 1'b0;
        end else begin
            have      = (kind_q.size() != 0);
            exp_busy  = have || m_done_pend;
            exp_done  = m_done_pend;
            exp_ready = have && (kind_q[0] == 1) && !bus.fifo_full;
            exp_wr    = have && !bus.fifo_full && ((kind_q[0] != 1) || bus.src_valid);
            check("busy", 32'(bus.busy), 32'(exp_busy));
            check("done", 32'(bus.done), 32'(exp_done));
            check("src_ready", 32'(bus.src_ready), 32'(exp_ready));
            check("fifo_wr_en", 32'(bus.fifo_wr_en), 32'(exp_wr));
            if (bus.fifo_wr_en) wr_log.push_back(bus.fifo_wdata);
            if (bus.busy) busy_cycles++;
            m_done_pend = 1'b0;
            if (exp_wr) begin
                check("fifo_wdata", 32'(bus.fifo_wdata), 32'(exp_q[0]));
                if (kind_q[0] == 2) m_done_pend = 1'b1;
                void'(exp_q.pop_front());
                void'(kind_q.pop_front());
            end else begin
                check("fifo_wdata_idle", 32'(bus.fifo_wdata), 32'd0);
            end
        end
    end

    always @(negedge wclk) begin
        if (wrstn) assert (!(bus.fifo_wr_en && bus.fifo_full))
            else $error("write strobe while fifo_full");
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic drive_src();
        if (src_q.size() == 0) begin
            bus.src_valid = 1'b0;
            bus.src_data  = DW'($urandom);
        end else begin
            bus.src_data  = src_q[0];
            bus.src_valid = (valid_mode == 1) ? cyc[0] : ($urandom_range(0, 99) < valid_pct);
        end
    endtask

    task automatic step();
        bit acc;
        @(negedge wclk);
        acc = bus.src_valid && bus.src_ready;
        @(posedge wclk);
        #1;
        cyc++;
        if (acc && src_q.size() != 0) void'(src_q.pop_front());
        if (full_hold > 0) begin
            bus.fifo_full = 1'b1;
            full_hold--;
        end else begin
            bus.fifo_full = ($urandom_range(0, 99) < full_pct);
        end
        drive_src();
        bus.start = 1'b0;
        bus.len   = LW'($urandom);
        // A start seen outside IDLE must be dropped by the DUT.
        if (model_busy() && ($urandom_range(0, 99) < ign_start_pct)) bus.start = 1'b1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (model_busy()) begin
            step();
            guard++;
            if (guard > 400) begin
                errors++;
                $display("FAIL idle_timeout actual=busy required=idle");
                exp_q.delete();
                kind_q.delete();
                m_done_pend = 1'b0;
                break;
            end
        end
    endtask

    task automatic start_pkt(input logic [LW-1:0] n);
        logic [DW-1:0] hdr;
        wait_idle();
        bus.start = 1'b1;
        bus.len   = n;
        src_q     = pay_q;
        step();
        hdr = '0;
        hdr[LW-1:0] = n;
        exp_q.push_back(hdr);
        kind_q.push_back(0);
        foreach (pay_q[i]) begin
            exp_q.push_back(pay_q[i]);
            kind_q.push_back(1);
        end
        exp_q.push_back(pkt_csum(n));
        kind_q.push_back(2);
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] exp[$]);
        check({name, "_count"}, 32'(wr_log.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < wr_log.size()) check({name, "_word"}, 32'(wr_log[i]), 32'(exp[i]));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] exp_log[$];
        int n;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.src_valid = 1'b0;
        bus.src_data  = '0;
        bus.fifo_full = 1'b0;

        repeat (3) step();
        wrstn = 1'b1;
        step();

        // Packet len 3, back-to-back payload, FIFO never full.
        pay_q = '{4'h1, 4'h2, 4'h4};
        check("t1_model_csum", 32'(pkt_csum(3)), 32'h4);
        wr_log.delete();
        busy_cycles = 0;
        start_pkt(3);
        wait_idle();
        step();
        exp_log = '{4'h3, 4'h1, 4'h2, 4'h4, 4'h4};
        check_log("t1_log", exp_log);
        check("t1_busy_cycles", 32'(busy_cycles), 32'd6);

        // Empty packet: header and checksum only.
        pay_q = {};
        check("t2_model_csum", 32'(pkt_csum(0)), 32'h0);
        wr_log.delete();
        start_pkt(0);
        wait_idle();
        exp_log = '{4'h0, 4'h0};
        check_log("t2_log", exp_log);

        // FIFO full for three cycles right after the first payload word.
        pay_q = '{4'hA, 4'h5};
        check("t3_model_csum", 32'(pkt_csum(2)), 32'hD);
        wr_log.delete();
        start_pkt(2);
        n = 0;
        while (exp_q.size() > 2 && n < 20) begin
            step();
            n++;
        end
        bus.fifo_full = 1'b1;
        full_hold = 2;
        wait_idle();
        exp_log = '{4'h2, 4'hA, 4'h5, 4'hD};
        check_log("t3_log", exp_log);

        // Maximum length with src_valid toggling each cycle.
        pay_q = {};
        for (int i = 1; i <= 15; i++) pay_q.push_back(DW'(i));
        check("t4_model_csum", 32'(pkt_csum(15)), 32'hF);
        wr_log.delete();
        valid_mode = 1;
        start_pkt(15);
        wait_idle();
        valid_mode = 0;
        check("t4_write_count", 32'(wr_log.size()), 32'd17);
        if (wr_log.size() == 17) check("t4_csum_word", 32'(wr_log[16]), 32'hF);

        // Starts raised while busy must be ignored; next real start is accepted.
        pay_q = '{4'h9, 4'h3, 4'hC};
        wr_log.delete();
        ign_start_pct = 100;
        start_pkt(3);
        wait_idle();
        ign_start_pct = 0;
        check("t5_write_count", 32'(wr_log.size()), 32'd5);
        pay_q = '{4'h7, 4'h1};
        wr_log.delete();
        start_pkt(2);
        wait_idle();
        exp_log = '{4'h2, 4'h7, 4'h1, 4'h4};
        check_log("t5_next_log", exp_log);

        // Reset in the middle of a payload.
        pay_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        start_pkt(5);
        n = 0;
        while (exp_q.size() > 4 && n < 20) begin
            step();
            n++;
        end
        wrstn = 1'b0;
        #1;
        check("t6_wr_en_drop", 32'(bus.fifo_wr_en), 32'd0);
        check("t6_ready_drop", 32'(bus.src_ready), 32'd0);
        check("t6_busy_drop", 32'(bus.busy), 32'd0);
        check("t6_done_drop", 32'(bus.done), 32'd0);
        src_q.delete();
        bus.src_valid = 1'b0;
        repeat (2) step();
        wrstn = 1'b1;
        step();
        pay_q = '{4'h6};
        check("t6_model_csum", 32'(pkt_csum(1)), 32'h7);
        wr_log.delete();
        start_pkt(1);
        wait_idle();
        exp_log = '{4'h1, 4'h6, 4'h7};
        check_log("t6_log", exp_log);

        // Randomized packets with stalls, gaps and ignored starts.
        for (int p = 0; p < 40; p++) begin
            n = $urandom_range(0, 15);
            pay_q = {};
            for (int i = 0; i < n; i++) pay_q.push_back(DW'($urandom));
            valid_pct     = $urandom_range(30, 100);
            full_pct      = $urandom_range(0, 40);
            ign_start_pct = $urandom_range(0, 30);
            start_pkt(LW'(n));
        end
        wait_idle();
        full_pct = 0;
        ign_start_pct = 0;
        repeat (3) step();
        check("final_model_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
